// File: rtl/pc_unit_if.sv
// pc_unit_if: decode-side control and target bundle feeding pc_unit,
// plus the fetch PC, interrupt and counter outputs it returns.
interface pc_unit_if #(
  parameter int AW    = 32,
  parameter int CNT_W = 32
);
  logic             pause;
  logic [2:0]       pc_gen_ctl;
  logic             br_taken_i;
  logic [AW-1:0]    id_pc_i;
  logic [AW-1:0]    ext_i;
  logic [AW-1:0]    rs_i;
  logic             irq_i;
  logic [AW-1:0]    irq_addr_i;
  logic [AW-1:0]    pc_o;
  logic [AW-1:0]    epc_o;
  logic             iack_o;
  logic             flush_o;
  logic             in_irq_o;
  logic [CNT_W-1:0] clk_no_o;
  logic [CNT_W-1:0] ins_no_o;

  modport master (
    output pause,
    output pc_gen_ctl,
    output br_taken_i,
    output id_pc_i,
    output ext_i,
    output rs_i,
    output irq_i,
    output irq_addr_i,
    input  pc_o,
    input  epc_o,
    input  iack_o,
    input  flush_o,
    input  in_irq_o,
    input  clk_no_o,
    input  ins_no_o
  );

  modport slave (
    input  pause,
    input  pc_gen_ctl,
    input  br_taken_i,
    input  id_pc_i,
    input  ext_i,
    input  rs_i,
    input  irq_i,
    input  irq_addr_i,
    output pc_o,
    output epc_o,
    output iack_o,
    output flush_o,
    output in_irq_o,
    output clk_no_o,
    output ins_no_o
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: registered fetch PC with next-PC select, interrupt entry
// FSM, saved EPC, iack/flush generation and CPI counters.
module pc_unit #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            CNT_W    = 32
) (
  input  logic     clk,
  input  logic     rst_i,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_TAKE   = 2'd1,
    S_IN_IRQ = 2'd2
  } state_t;

  localparam logic [2:0] C_RET = 3'd1;
  localparam logic [2:0] C_J   = 3'd2;
  localparam logic [2:0] C_JR  = 3'd3;
  localparam logic [2:0] C_BC  = 3'd4;

  localparam logic [AW-1:0]    PC_STEP = AW'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic             irq_pend_q;
  logic             irq_pend_d;
  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    pc_d;
  logic [AW-1:0]    epc_q;
  logic [AW-1:0]    epc_d;
  logic             iack_q;
  logic             iack_d;
  logic             flush;
  logic             in_irq;
  logic [CNT_W-1:0] clk_no_q;
  logic [CNT_W-1:0] ins_no_q;

  logic             is_next;
  logic             is_ret;
  logic             is_j;
  logic             is_jr;
  logic             is_bc;
  logic             redirect;
  logic [AW-1:0]    pc_plus4;
  logic [AW-1:0]    br_tgt;
  logic [AW-1:0]    j_tgt;
  logic [AW-1:0]    seq_pc;

  assign pc_plus4 = pc_q + PC_STEP;
  assign br_tgt   = bus.id_pc_i + bus.ext_i;
  assign j_tgt    = {bus.id_pc_i[AW-1:28], bus.ext_i[27:0]};

  // Decode the control field; unused encodings behave as NEXT.
  always_comb begin
    is_next = 1'b0;
    is_ret  = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    is_bc   = 1'b0;
    unique case (bus.pc_gen_ctl)
      C_RET:   is_ret  = 1'b1;
      C_J:     is_j    = 1'b1;
      C_JR:    is_jr   = 1'b1;
      C_BC:    is_bc   = 1'b1;
      default: is_next = 1'b1;
    endcase
  end

  assign redirect = is_ret | is_j | is_jr
                  | (is_bc & bus.br_taken_i);

  // Candidate PC for a normal, unpaused, non-interrupt cycle.
  always_comb begin
    seq_pc = pc_plus4;
    unique case (1'b1)
      is_ret:  seq_pc = epc_q;
      is_j:    seq_pc = j_tgt;
      is_jr:   seq_pc = bus.rs_i;
      is_bc:   seq_pc = bus.br_taken_i ? br_tgt : pc_plus4;
      default: seq_pc = pc_plus4;
    endcase
  end

  // Next-state, next-PC and same-cycle flush/in_irq decode.
  always_comb begin
    state_d    = state_q;
    irq_pend_d = irq_pend_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    iack_d     = 1'b0;
    flush      = 1'b0;
    in_irq     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (bus.irq_i) begin
          irq_pend_d = 1'b1;
        end
        if (!bus.pause) begin
          if (irq_pend_q && is_next) begin
            state_d    = S_TAKE;
            irq_pend_d = 1'b0;
            iack_d     = 1'b1;
          end else begin
            pc_d  = seq_pc;
            flush = redirect;
          end
        end
      end
      S_TAKE: begin
        flush   = 1'b1;
        epc_d   = pc_q;
        pc_d    = bus.irq_addr_i;
        state_d = S_IN_IRQ;
      end
      S_IN_IRQ: begin
        in_irq = 1'b1;
        if (!bus.pause) begin
          pc_d  = seq_pc;
          flush = redirect;
          if (is_ret) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // FSM state, pending IRQ and acknowledge registers.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_RUN;
      irq_pend_q <= 1'b0;
      iack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      iack_q     <= iack_d;
    end
  end

  // Fetch PC and saved exception PC.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  // Free-running cycle counter and unpaused-cycle counter.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      clk_no_q <= '0;
      ins_no_q <= '0;
    end else begin
      clk_no_q <= clk_no_q + CNT_ONE;
      if (!bus.pause) begin
        ins_no_q <= ins_no_q + CNT_ONE;
      end
    end
  end

  assign bus.pc_o     = pc_q;
  assign bus.epc_o    = epc_q;
  assign bus.iack_o   = iack_q;
  assign bus.flush_o  = flush;
  assign bus.in_irq_o = in_irq;
  assign bus.clk_no_o = clk_no_q;
  assign bus.ins_no_o = ins_no_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus hand sequences for IRQ entry,
// deferred take, pause, counter wrap and asynchronous reset.
module tb_pc_unit;

  localparam int AW    = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] NXT = 3'd0;
  localparam logic [2:0] RET = 3'd1;
  localparam logic [2:0] JMP = 3'd2;
  localparam logic [2:0] JR  = 3'd3;
  localparam logic [2:0] BC  = 3'd4;

  logic clk;
  logic rst_i;

  pc_unit_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  pc_unit #(
    .AW(AW),
    .RESET_PC(32'h0),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_i(rst_i),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0] clk_m;
  logic [CNT_W-1:0] ins_m;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      clk_m <= '0;
      ins_m <= '0;
    end else begin
      clk_m <= clk_m + 1'b1;
      if (!bus.pause) ins_m <= ins_m + 1'b1;
    end
  end

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic p, input logic [2:0] c,
                        input logic br, input logic [31:0] idpc,
                        input logic [31:0] ext, input logic [31:0] rs);
    bus.pause      = p;
    bus.pc_gen_ctl = c;
    bus.br_taken_i = br;
    bus.id_pc_i    = idpc;
    bus.ext_i      = ext;
    bus.rs_i       = rs;
  endtask

  typedef struct {
    string       name;
    logic        pause;
    logic [2:0]  ctl;
    logic        br;
    logic [31:0] id_pc;
    logic [31:0] ext;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  vec_t vt[$];
  logic [CNT_W-1:0] c0;
  logic [CNT_W-1:0] i0;

  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b0;
    bus.irq_i      = 1'b0;
    bus.irq_addr_i = 32'h0;
    set_in(1'b0, NXT, 1'b0, 32'h0, 32'h0, 32'h0);

    vt.push_back('{"next1", 0, NXT, 0, 32'h0, 32'h0, 32'h0, 32'h4, 0});
    vt.push_back('{"next2", 0, NXT, 0, 32'h0, 32'h0, 32'h0, 32'h8, 0});
    vt.push_back('{"next3", 0, NXT, 0, 32'h0, 32'h0, 32'h0, 32'hC, 0});
    vt.push_back('{"j", 0, JMP, 0, 32'h3000_0000, 32'h0000_0100,
                   32'h0, 32'h3000_0100, 1});
    vt.push_back('{"jr", 0, JR, 0, 32'h0, 32'h0, 32'h100, 32'h100, 1});
    vt.push_back('{"bc_tk", 0, BC, 1, 32'h100, 32'hFFFF_FFF8,
                   32'h0, 32'hF8, 1});
    vt.push_back('{"jr104", 0, JR, 0, 32'h0, 32'h0, 32'h104, 32'h104, 1});
    vt.push_back('{"bc_nt", 0, BC, 0, 32'h100, 32'hFFFF_FFF8,
                   32'h0, 32'h108, 0});
    vt.push_back('{"ctl5", 0, 3'd5, 0, 32'h0, 32'h0, 32'h0, 32'h10C, 0});
    vt.push_back('{"ctl7", 0, 3'd7, 1, 32'h0, 32'h0, 32'h0, 32'h110, 0});
    vt.push_back('{"ret_run", 0, RET, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1});
    vt.push_back('{"pause_j", 1, JMP, 0, 32'h3000_0000, 32'h100,
                   32'h0, 32'h0, 0});
    vt.push_back('{"pause_bc", 1, BC, 1, 32'h100, 32'h8,
                   32'h0, 32'h0, 0});
    vt.push_back('{"bc_wrap", 0, BC, 1, 32'hFFFF_FFFC, 32'h8,
                   32'h0, 32'h4, 1});
    vt.push_back('{"jr_top", 0, JR, 0, 32'h0, 32'h0, 32'hFFFF_FFFC,
                   32'hFFFF_FFFC, 1});
    vt.push_back('{"next_wrap", 0, NXT, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0});
    vt.push_back('{"j_hi", 0, JMP, 0, 32'hA000_0000, 32'hF123_4568,
                   32'h0, 32'hA123_4568, 1});
    vt.push_back('{"next_a", 0, NXT, 0, 32'h0, 32'h0, 32'h0,
                   32'hA123_456C, 0});

    // reset state
    step();
    step();
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_epc", bus.epc_o, 32'h0);
    chk("rst_iack", bus.iack_o, 1'b0);
    chk("rst_flush", bus.flush_o, 1'b0);
    chk("rst_in_irq", bus.in_irq_o, 1'b0);
    chk("rst_clk_no", bus.clk_no_o, 6'd0);
    chk("rst_ins_no", bus.ins_no_o, 6'd0);
    rst_i = 1'b1;

    // vector table
    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].pause, vt[i].ctl, vt[i].br, vt[i].id_pc,
             vt[i].ext, vt[i].rs);
      #1;
      chk({vt[i].name, "_flush"}, bus.flush_o, vt[i].exp_flush);
      step();
      chk({vt[i].name, "_pc"}, bus.pc_o, vt[i].exp_pc);
      chk({vt[i].name, "_clk"}, bus.clk_no_o, clk_m);
      chk({vt[i].name, "_ins"}, bus.ins_no_o, ins_m);
      if (i == 2) begin
        chk("clk_no_3", bus.clk_no_o, 6'd3);
        chk("ins_no_3", bus.ins_no_o, 6'd3);
      end
    end

    // IRQ entry, dropped second request, return
    bus.irq_addr_i = 32'h1000;
    set_in(0, JR, 0, 32'h0, 32'h0, 32'h3C);
    step();
    chk("irq_pre_pc", bus.pc_o, 32'h3C);
    bus.irq_i = 1'b1;
    set_in(0, NXT, 0, 32'h0, 32'h0, 32'h0);
    step();
    bus.irq_i = 1'b0;
    chk("irq_n_pc", bus.pc_o, 32'h40);
    chk("irq_n_iack", bus.iack_o, 1'b0);
    step();
    chk("take_pc", bus.pc_o, 32'h40);
    chk("take_iack", bus.iack_o, 1'b1);
    chk("take_flush", bus.flush_o, 1'b1);
    chk("take_in_irq", bus.in_irq_o, 1'b0);
    set_in(1, JMP, 0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("take_flush_paused", bus.flush_o, 1'b1);
    step();
    chk("hdl_pc", bus.pc_o, 32'h1000);
    chk("hdl_epc", bus.epc_o, 32'h40);
    chk("hdl_iack", bus.iack_o, 1'b0);
    chk("hdl_in_irq", bus.in_irq_o, 1'b1);
    set_in(0, NXT, 0, 32'h0, 32'h0, 32'h0);
    bus.irq_i = 1'b1;
    step();
    bus.irq_i = 1'b0;
    chk("hdl2_pc", bus.pc_o, 32'h1004);
    chk("hdl2_iack", bus.iack_o, 1'b0);
    step();
    chk("hdl3_pc", bus.pc_o, 32'h1008);
    chk("hdl3_iack", bus.iack_o, 1'b0);
    set_in(0, RET, 0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("ret_flush", bus.flush_o, 1'b1);
    step();
    chk("ret_pc", bus.pc_o, 32'h40);
    chk("ret_in_irq", bus.in_irq_o, 1'b0);
    set_in(0, NXT, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk("drop1_iack", bus.iack_o, 1'b0);
    chk("drop1_pc", bus.pc_o, 32'h44);
    step();
    chk("drop2_iack", bus.iack_o, 1'b0);
    chk("drop2_pc", bus.pc_o, 32'h48);

    // IRQ pending across a jump is deferred to the next NEXT
    bus.irq_addr_i = 32'h2000;
    bus.irq_i = 1'b1;
    set_in(0, JMP, 0, 32'h100, 32'h0800_0200, 32'h0);
    #1;
    chk("jirq_flush", bus.flush_o, 1'b1);
    step();
    bus.irq_i = 1'b0;
    chk("jirq_pc", bus.pc_o, 32'h0800_0200);
    chk("jirq_iack", bus.iack_o, 1'b0);
    set_in(0, NXT, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk("jtake_iack", bus.iack_o, 1'b1);
    chk("jtake_pc", bus.pc_o, 32'h0800_0200);
    step();
    chk("jhdl_pc", bus.pc_o, 32'h2000);
    chk("jhdl_epc", bus.epc_o, 32'h0800_0200);
    chk("jhdl_in_irq", bus.in_irq_o, 1'b1);
    set_in(0, RET, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk("jret_pc", bus.pc_o, 32'h0800_0200);
    chk("jret_in_irq", bus.in_irq_o, 1'b0);

    // pause held five cycles
    set_in(0, JR, 0, 32'h0, 32'h0, 32'h20);
    step();
    chk("pz_pc0", bus.pc_o, 32'h20);
    c0 = clk_m;
    i0 = ins_m;
    set_in(1, NXT, 0, 32'h0, 32'h0, 32'h0);
    repeat (5) step();
    chk("pz_pc", bus.pc_o, 32'h20);
    chk("pz_ins", bus.ins_no_o, i0);
    chk("pz_clk", bus.clk_no_o, c0 + 6'd5);
    set_in(0, NXT, 0, 32'h0, 32'h0, 32'h0);

    // counter wrap
    for (int k = 0; k < 80 && clk_m != 6'h3F; k++) step();
    chk("clk_top", bus.clk_no_o, 6'h3F);
    step();
    chk("clk_wrap", bus.clk_no_o, 6'h0);
    for (int k = 0; k < 80 && ins_m != 6'h3F; k++) step();
    chk("ins_top", bus.ins_no_o, 6'h3F);
    step();
    chk("ins_wrap", bus.ins_no_o, 6'h0);

    // asynchronous reset during TAKE
    bus.irq_addr_i = 32'h3000;
    bus.irq_i = 1'b1;
    step();
    bus.irq_i = 1'b0;
    step();
    chk("ar_take_iack", bus.iack_o, 1'b1);
    #3;
    rst_i = 1'b0;
    #1;
    chk("ar_pc", bus.pc_o, 32'h0);
    chk("ar_epc", bus.epc_o, 32'h0);
    chk("ar_iack", bus.iack_o, 1'b0);
    chk("ar_flush", bus.flush_o, 1'b0);
    chk("ar_in_irq", bus.in_irq_o, 1'b0);
    chk("ar_clk_no", bus.clk_no_o, 6'd0);
    chk("ar_ins_no", bus.ins_no_o, 6'd0);
    @(negedge clk);
    rst_i = 1'b1;
    set_in(1, NXT, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk("rel_pause_pc", bus.pc_o, 32'h0);
    set_in(0, NXT, 0, 32'h0, 32'h0, 32'h0);
    step();
    chk("rel_pc", bus.pc_o, 32'h4);
    chk("rel_clk_no", bus.clk_no_o, 6'd2);
    chk("rel_ins_no", bus.ins_no_o, 6'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised, registered program-counter unit for the mips789 fetch path. It generalises the combinational next-PC selection of the decode stage: configurable address width and reset vector, an internal interrupt-entry state machine with a saved exception PC, and an iack handshake. It also has free-running clock and retired-fetch counters for CPI measurement. It sits between the decode stage, which supplies control, targets and compare results, and the instruction fetch port.

## Interface
- AW, 32: address width; minimum 29.
- RESET_PC, 0: value loaded into pc_o on reset.
- CNT_W, 32: width of the clk_no_o and ins_no_o counters.
- clk  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- pause  in  1  pipeline stall; freezes PC, FSM and ins_no_o.
- pc_gen_ctl  in  3  decode control: 0 NEXT, 1 RET, 2 J, 3 JR, 4 BC; 5–7 treated as NEXT.
- br_taken_i  in  1  branch compare result, qualified by BC.
- id_pc_i  in  AW  PC of the instruction in decode.
- ext_i  in  AW  immediate from the extend unit, already shifted and sign-extended.
- rs_i  in  AW  forwarded rs value, used by JR.
- irq_i  in  1  level interrupt request.
- irq_addr_i  in  AW  interrupt vector.
- pc_o  out  AW  current fetch PC.
- epc_o  out  AW  saved exception PC.
- iack_o  out  1  one-cycle interrupt acknowledge.
- flush_o  out  1  one-cycle squash request for the fetch/decode registers.
- in_irq_o  out  1  high while in handler state.
- clk_no_o  out  CNT_W  cycle counter.
- ins_no_o  out  CNT_W  count of non-paused cycles.

## Operation
- Next PC in RUN and IN_IRQ, when not paused and no IRQ is taken:
  - NEXT: pc_o+4.
  - J: {id_pc_i[AW-1:28], ext_i[27:0]}.
  - JR: rs_i.
  - BC: id_pc_i+ext_i if br_taken_i, else pc_o+4.
  - RET: epc_o.
- All additions are modulo 2^AW; there is no carry-out.
- irq_pend register:
  - Set when irq_i=1 in a cycle where state is RUN.
  - Cleared on IRQ take.
  - Ignored (not set) in IN_IRQ, so requests arriving in IN_IRQ are dropped, not queued.
- FSM states:
  - RUN → TAKE when irq_pend=1, pause=0 and pc_gen_ctl resolves to NEXT. IRQs are never taken under an in-flight control transfer.
  - TAKE: lasts exactly one cycle and ignores pause.
    - epc_o ← pc_o; pc_o ← irq_addr_i.
    - iack_o=1 and flush_o=1.
    - Next state is IN_IRQ.
  - IN_IRQ: in_irq_o=1; normal next-PC rules apply.
  - IN_IRQ → RUN when pc_gen_ctl=RET and pause=0 (pc_o ← epc_o).
  - RET in RUN also loads epc_o; no state change.
- flush_o is also 1 for one cycle on any taken J, JR, RET, or BC with br_taken_i=1, when pause=0.
- pause=1 in RUN or IN_IRQ:
  - pc_o, epc_o, state and ins_no_o hold.
  - irq_pend may still be set.
  - clk_no_o still counts.
- Counters:
  - clk_no_o increments every cycle after reset.
  - ins_no_o increments on every cycle with pause=0.
  - Both wrap from 2^CNT_W−1 to 0.
- Reset (asynchronous assert, at any time, including mid-TAKE):
  - pc_o=RESET_PC, epc_o=0, state RUN, irq_pend=0.
  - iack_o=0, flush_o=0, in_irq_o=0, clk_no_o=0, ins_no_o=0.

## Timing
- All outputs are registered except flush_o and in_irq_o, which are decoded from current state and inputs in the same cycle.
- Redirect latency:
  - The target is on pc_o in the cycle after the control is sampled.
  - flush_o is high in the sampling cycle.
- IRQ latency, with irq_i sampled high at edge N in RUN and the pipe unpaused with NEXT: irq_pend=1 after edge N, TAKE during cycle N+1, pc_o=irq_addr_i after edge N+2.
- iack_o is high exactly one cycle, coincident with TAKE.
- On reset release, the first pc_o change occurs at the first rising edge with rst_i=1 and pause=0.

## Test plan
- Reset, then 3 unpaused NEXT cycles with RESET_PC=0x00000000 → pc_o 0x4, 0x8, 0xC; clk_no_o=3, ins_no_o=3.
- BC with id_pc_i=0x100, ext_i=0xFFFFFFF8, br_taken_i=1 → pc_o=0xF8 next cycle, flush_o=1. Same with br_taken_i=0 and pc_o=0x104 → pc_o=0x108, flush_o=0.
- pc_o=0x40, irq_i pulsed one cycle, irq_addr_i=0x1000 → iack_o one cycle, epc_o=0x40, pc_o=0x1000, in_irq_o=1. Second irq_i while in IN_IRQ → no iack_o. RET → pc_o=0x40, state RUN.
- irq_pend set while pc_gen_ctl=J (target 0x0800_0200) → J taken first; TAKE occurs on the following NEXT cycle and epc_o=0x0800_0200.
- pause held 5 cycles at pc_o=0x20 → pc_o, ins_no_o frozen, clk_no_o +5. Force counters to 2^CNT_W−1 → both wrap to 0.
- Assert rst_i=0 asynchronously during TAKE → all outputs at reset values immediately, before the next clock edge.
